bus_arbiter: RTL

- Shares the system bus between the two bus masters. Each master is driven by the command processor's read1/write1 and read2/write2 strobes.
- Grants exactly one master at a time and drives the master-select for the address/data/control muxes.
- Supports split transactions: a slow slave can release the bus and later resume the parked master.
- Fixed priority to master 1, with a starvation guard for master 2.

---
 rtl/bus_arbiter_if.sv | 24 ++
 rtl/bus_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/bus_arbiter_if.sv
// Bus arbitration interface: master requests and split signalling in,
// grants, mux select and split status out.
interface bus_arbiter_if;
    logic mreq1;
    logic mreq2;
    logic split;
    logic split_done;
    logic mgrant1;
    logic mgrant2;
    logic msel;
    logic bus_busy;
    logic split_pending;
    logic split_id;

    modport master (
        output mreq1, mreq2, split, split_done,
        input  mgrant1, mgrant2, msel, bus_busy, split_pending, split_id
    );

    modport slave (
        input  mreq1, mreq2, split, split_done,
        output mgrant1, mgrant2, msel, bus_busy, split_pending, split_id
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: fixed priority to master 1, starvation guard for
// master 2, and split-transaction park/resume. All outputs registered.
module bus_arbiter #(
    parameter int unsigned STARVE_LEN = 4,
    parameter int unsigned STARVE_MAX = 15
) (
    input  logic         clk,
    input  logic         reset,
    bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT1, GRANT2, RELEASE} state_t;

    localparam logic [STARVE_LEN-1:0] STARVE_TOP = STARVE_LEN'(STARVE_MAX);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_grant1, r_grant2, r_msel, r_busy;
    logic                  r_pend, r_id, r_resume;
    logic [STARVE_LEN-1:0] r_starve;

    logic                  w_grant1_nxt, w_grant2_nxt, w_msel_nxt;
    logic                  w_pend_nxt, w_id_nxt, w_resume_nxt;
    logic [STARVE_LEN-1:0] w_starve_nxt;
    logic                  w_elig1, w_elig2, w_starved;
    logic                  w_resume1, w_resume2, w_parked_req;

    assign w_elig1      = bus.mreq1 && !(r_pend && !r_id);
    assign w_elig2      = bus.mreq2 && !(r_pend &&  r_id);
    assign w_starved    = (r_starve == STARVE_TOP) && w_elig2;
    assign w_resume1    = r_resume && !r_id && w_elig1;
    assign w_resume2    = r_resume &&  r_id && w_elig2;
    assign w_parked_req = r_id ? bus.mreq2 : bus.mreq1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_grant1 <= 1'b0;
            r_grant2 <= 1'b0;
            r_msel   <= 1'b0;
            r_busy   <= 1'b0;
            r_pend   <= 1'b0;
            r_id     <= 1'b0;
            r_resume <= 1'b0;
            r_starve <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant1 <= w_grant1_nxt;
            r_grant2 <= w_grant2_nxt;
            r_msel   <= w_msel_nxt;
            r_busy   <= w_grant1_nxt | w_grant2_nxt;
            r_pend   <= w_pend_nxt;
            r_id     <= w_id_nxt;
            r_resume <= w_resume_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_resume1)      w_state_nxt = GRANT1;
                else if (w_resume2) w_state_nxt = GRANT2;
                else if (w_starved) w_state_nxt = GRANT2;
                else if (w_elig1)   w_state_nxt = GRANT1;
                else if (w_elig2)   w_state_nxt = GRANT2;
            end
            GRANT1:  if (!bus.mreq1 || (bus.split && !r_pend)) w_state_nxt = RELEASE;
            GRANT2:  if (!bus.mreq2 || (bus.split && !r_pend)) w_state_nxt = RELEASE;
            RELEASE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_grant1_nxt = (w_state_nxt == GRANT1);
        w_grant2_nxt = (w_state_nxt == GRANT2);
        w_msel_nxt   = r_msel;
        if (w_grant1_nxt)      w_msel_nxt = 1'b0;
        else if (w_grant2_nxt) w_msel_nxt = 1'b1;

        w_pend_nxt   = r_pend;
        w_id_nxt     = r_id;
        w_resume_nxt = r_resume;
        if (r_state == IDLE && w_state_nxt != IDLE) w_resume_nxt = 1'b0;

        // A request drop outranks a same-cycle split; split_id survives the
        // clear so the resume path still knows whom to favour.
        if (r_state == GRANT1 && bus.mreq1 && bus.split && !r_pend) begin
            w_pend_nxt = 1'b1;
            w_id_nxt   = 1'b0;
        end else if (r_state == GRANT2 && bus.mreq2 && bus.split && !r_pend) begin
            w_pend_nxt = 1'b1;
            w_id_nxt   = 1'b1;
        end else if (r_pend) begin
            if (!w_parked_req) begin
                w_pend_nxt = 1'b0;
            end else if (bus.split_done) begin
                w_pend_nxt   = 1'b0;
                w_resume_nxt = 1'b1;
            end
        end

        w_starve_nxt = r_starve;
        if (!bus.mreq2 || w_grant2_nxt)
            w_starve_nxt = '0;
        else if (w_elig2 && !r_grant2 && r_starve != STARVE_TOP)
            w_starve_nxt = r_starve + STARVE_LEN'(1);
    end

    assign bus.mgrant1       = r_grant1;
    assign bus.mgrant2       = r_grant2;
    assign bus.msel          = r_msel;
    assign bus.bus_busy      = r_busy;
    assign bus.split_pending = r_pend;
    assign bus.split_id      = r_id;
endmodule
